matrix_row_driver: RTL and testbench
====================================

// Module: matrix_row_driver
// PURPOSE
//   Row-side stage downstream of the 3-bit column ring counter on the 5-column LED matrix.
//   Decodes the one-hot column into a 7-bit row pattern, mirrored so col[2] drives outer
//   columns 0/4, col[1] drives 1/3 and col[0] drives centre column 2.
//   Adds anti-ghost blanking on every column change, frame-synchronous pattern latching,
//   optional blinking, and detection of an illegal (non-one-hot) ring state.
// PARAMETERS
//   BLANK_CYCLES  2  clocks rows are held dark after each column change (0..15)
//   BLINK_FRAMES  8  frames per blink half-period (1..255)
//   FAULT_CYCLES  4  consecutive illegal-column clocks before col_fault asserts (1..15)
// PORTS
//   clock        in   1  single system clock, rising edge
//   reset        in   1  asynchronous, active-high
//   col          in   3  one-hot column from ring counter; legal sequence 100->010->001->100
//   pattern_sel  in   2  irrigation level icon: 0 idle, 1 low, 2 medium, 3 high
//   blink_en     in   1  1 = blink the icon at BLINK_FRAMES rate
//   row          out  7  row drive, active-high, bit0 = bottom row, registered
//   frame_start  out  1  1-clock pulse when a frame begins (col enters 100)
//   col_fault    out  1  ring counter stuck in illegal state
// BEHAVIOUR
// - Reset (async, active-high): row=0, frame_start=0, col_fault=0, col_q=000, pat_q=0,
//   blank_cnt=0, frame_cnt=0, blink phase=ON, fault_cnt=0. Leaving reset, the first legal col
//   counts as a change.
// - col legal iff exactly one bit set. col_q registers col each clock.
// - Pattern ROM (outer, mid, centre):
//   P0 00,00,08 | P1 01,03,07 | P2 07,0F,1F | P3 1F,3F,7F (hex).
// - Column change: legal col != col_q sampled at edge N.
//   - At N: blank_cnt <= BLANK_CYCLES, row <= 0; if BLANK_CYCLES=0, row <= ROM[new col].
//   - Nonzero blank_cnt decrements each clock; row <= ROM[pat_q][col] at edge N+BLANK_CYCLES.
//   - A further change during blanking restarts the count.
// - Frame: change to col=100 at edge N -> frame_start=1 for the cycle after N.
//   - pat_q <= pattern_sel at N; that value applies for the whole frame, including the 100
//     column. pattern_sel changes mid-frame are ignored until the next frame_start.
// - Blink: frame_cnt increments per frame_start; at BLINK_FRAMES-1 it wraps to 0 and the
//   phase toggles.
//   - blink_en=1 and phase OFF -> row forced 0, blanking/decoding otherwise unchanged.
//   - blink_en=0 -> phase ignored (frame_cnt keeps running).
// - Illegal col (000 or more than one bit set):
//   - row <= 0 on the next edge; fault_cnt increments, saturating at 15.
//   - fault_cnt reaching FAULT_CYCLES -> col_fault=1 (sticky).
//   - Any legal clock clears fault_cnt. col_fault clears only at the next frame_start or reset.
//   - Return to legal col = column change (blanking applies).
// - Steady legal col with no change: row holds the ROM value, gated by blink.
// - Reset mid-frame: all state to reset values immediately; no partial-frame pattern retained.
// TESTING
// 1 Reset, BLANK=2, sel=2, ring 100/010/001 every 10 clk -> frame_start pulse at first 100;
//   row 0 for 2 clk after each change, then 07, 0F, 1F.
// 2 sel 1->3 while col=010 -> row stays 03 in this frame; after next frame_start row = 1F
//   (outer).
// 3 BLANK_CYCLES=0, col change at edge N -> row shows new pattern after edge N, no dark cycle.
// 4 Force col=000 for 3 clk then 100 -> row 0, col_fault stays 0; force 111 for 4 clk ->
//   col_fault=1; stays 1 until next frame_start.
// 5 blink_en=1, BLINK_FRAMES=2 -> rows alternate lit/dark every 2 frames; blink_en=0 ->
//   always lit.
// 6 Assert reset mid-blank with sel=3 latched -> row=0, pat_q=0; after release first 100
//   yields frame_start.

Source files
------------

// File: rtl/matrix_row_driver.sv
// Row-side stage of the 5-column LED matrix: decodes the one-hot ring column into a
// mirrored 7-bit row icon with anti-ghost blanking, frame-synchronous pattern latch and blink.
module matrix_row_driver #(
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 8,
  parameter int FAULT_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] col,
  input  logic [1:0] pattern_sel,
  input  logic       blink_en,
  output logic [6:0] row,
  output logic       frame_start,
  output logic       col_fault
);

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_t;

  logic [2:0] colQ;
  logic [1:0] patQ;
  logic [3:0] blankCnt;
  logic [7:0] frameCnt;
  phase_t     phase;
  logic [3:0] faultCnt;

  logic       colLegal;
  logic       colChange;
  logic       frameBegin;
  logic [1:0] patEff;
  logic [6:0] romValue;
  logic [3:0] blankNext;
  logic [7:0] frameCntNext;
  phase_t     phaseNext;
  logic       lit;
  logic [6:0] rowNext;
  logic [3:0] faultCntNext;
  logic       colFaultNext;

  // Icon ROM: col[2] feeds the outer column pair, col[1] the inner pair, col[0] the centre
  function automatic logic [6:0] romLookup(input logic [1:0] sel, input logic [2:0] c);
    logic [6:0] outer;
    logic [6:0] mid;
    logic [6:0] centre;
    outer  = 7'h00;
    mid    = 7'h00;
    centre = 7'h00;
    case (sel)
      2'd0: begin outer = 7'h00; mid = 7'h00; centre = 7'h08; end
      2'd1: begin outer = 7'h01; mid = 7'h03; centre = 7'h07; end
      2'd2: begin outer = 7'h07; mid = 7'h0F; centre = 7'h1F; end
      default: begin outer = 7'h1F; mid = 7'h3F; centre = 7'h7F; end
    endcase
    case (c)
      3'b100:  romLookup = outer;
      3'b010:  romLookup = mid;
      3'b001:  romLookup = centre;
      default: romLookup = 7'h00;
    endcase
  endfunction

  always_comb begin
    colLegal   = (col == 3'b100) || (col == 3'b010) || (col == 3'b001);
    colChange  = colLegal && (col != colQ);
    frameBegin = colChange && (col == 3'b100);
    // The new frame's selection must already apply to its first (outer) column
    patEff     = frameBegin ? pattern_sel : patQ;
    romValue   = romLookup(patEff, col);

    blankNext = 4'd0;
    if (colChange)
      blankNext = 4'(BLANK_CYCLES);
    else if (blankCnt != 4'd0)
      blankNext = blankCnt - 4'd1;

    frameCntNext = frameCnt;
    phaseNext    = phase;
    if (frameBegin) begin
      if (frameCnt == 8'(BLINK_FRAMES - 1)) begin
        frameCntNext = 8'd0;
        phaseNext    = (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        frameCntNext = frameCnt + 8'd1;
      end
    end

    // A count of 1 expires on this edge, so the row lights exactly BLANK_CYCLES after the change
    lit = 1'b0;
    if (colLegal)
      lit = colChange ? (BLANK_CYCLES == 0) : (blankCnt <= 4'd1);

    rowNext = 7'h00;
    if (lit && (!blink_en || (phaseNext == PHASE_ON)))
      rowNext = romValue;

    faultCntNext = 4'd0;
    if (!colLegal)
      faultCntNext = (faultCnt == 4'd15) ? 4'd15 : faultCnt + 4'd1;

    colFaultNext = col_fault;
    if (frameBegin)
      colFaultNext = 1'b0;
    else if (faultCntNext >= 4'(FAULT_CYCLES))
      colFaultNext = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      colQ        <= 3'b000;
      patQ        <= 2'd0;
      blankCnt    <= 4'd0;
      frameCnt    <= 8'd0;
      phase       <= PHASE_ON;
      faultCnt    <= 4'd0;
      row         <= 7'h00;
      frame_start <= 1'b0;
      col_fault   <= 1'b0;
    end else begin
      colQ        <= col;
      patQ        <= patEff;
      blankCnt    <= blankNext;
      frameCnt    <= frameCntNext;
      phase       <= phaseNext;
      faultCnt    <= faultCntNext;
      row         <= rowNext;
      frame_start <= frameBegin;
      col_fault   <= colFaultNext;
    end
  end

endmodule

// File: tb/tb_matrix_row_driver.sv
// Directed bench for matrix_row_driver: instance A blanks for 2 clocks and blinks every
// 2 frames, instance B has no blanking and an 8-frame blink period; both share stimulus.
module tb_matrix_row_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] col = 3'b000;
  logic [1:0] patternSel = 2'd0;
  logic       blinkEn = 1'b0;

  logic [6:0] rowA;
  logic       frameStartA;
  logic       colFaultA;
  logic [6:0] rowB;
  logic       frameStartB;
  logic       colFaultB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] col;
    logic [1:0] sel;
    logic [6:0] rowA;
    logic       fs;
    logic       fault;
    logic [6:0] rowB;
  } vec_t;

  vec_t vecs [38];

  matrix_row_driver #(.BLANK_CYCLES(2), .BLINK_FRAMES(2), .FAULT_CYCLES(4)) dutA (
    .clock(clock), .reset(reset), .col(col), .pattern_sel(patternSel), .blink_en(blinkEn),
    .row(rowA), .frame_start(frameStartA), .col_fault(colFaultA)
  );

  matrix_row_driver #(.BLANK_CYCLES(0), .BLINK_FRAMES(8), .FAULT_CYCLES(4)) dutB (
    .clock(clock), .reset(reset), .col(col), .pattern_sel(patternSel), .blink_en(blinkEn),
    .row(rowB), .frame_start(frameStartB), .col_fault(colFaultB)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [2:0] c, input logic [1:0] s, input logic b);
    col        = c;
    patternSel = s;
    blinkEn    = b;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  logic [6:0] litA;
  logic [6:0] litB;

  initial begin
    // col, sel, rowA, frame_start, col_fault, rowB
    vecs[0]  = '{3'b100, 2'd2, 7'h00, 1'b1, 1'b0, 7'h07};
    vecs[1]  = '{3'b100, 2'd2, 7'h00, 1'b0, 1'b0, 7'h07};
    vecs[2]  = '{3'b100, 2'd2, 7'h07, 1'b0, 1'b0, 7'h07};
    vecs[3]  = '{3'b100, 2'd2, 7'h07, 1'b0, 1'b0, 7'h07};
    vecs[4]  = '{3'b010, 2'd2, 7'h00, 1'b0, 1'b0, 7'h0F};
    vecs[5]  = '{3'b010, 2'd2, 7'h00, 1'b0, 1'b0, 7'h0F};
    vecs[6]  = '{3'b010, 2'd1, 7'h0F, 1'b0, 1'b0, 7'h0F};
    vecs[7]  = '{3'b001, 2'd1, 7'h00, 1'b0, 1'b0, 7'h1F};
    vecs[8]  = '{3'b001, 2'd1, 7'h00, 1'b0, 1'b0, 7'h1F};
    vecs[9]  = '{3'b001, 2'd1, 7'h1F, 1'b0, 1'b0, 7'h1F};
    vecs[10] = '{3'b100, 2'd3, 7'h00, 1'b1, 1'b0, 7'h1F};
    vecs[11] = '{3'b100, 2'd3, 7'h00, 1'b0, 1'b0, 7'h1F};
    vecs[12] = '{3'b100, 2'd3, 7'h1F, 1'b0, 1'b0, 7'h1F};
    vecs[13] = '{3'b010, 2'd0, 7'h00, 1'b0, 1'b0, 7'h3F};
    vecs[14] = '{3'b010, 2'd0, 7'h00, 1'b0, 1'b0, 7'h3F};
    vecs[15] = '{3'b010, 2'd0, 7'h3F, 1'b0, 1'b0, 7'h3F};
    vecs[16] = '{3'b001, 2'd0, 7'h00, 1'b0, 1'b0, 7'h7F};
    vecs[17] = '{3'b010, 2'd0, 7'h00, 1'b0, 1'b0, 7'h3F};
    vecs[18] = '{3'b010, 2'd0, 7'h00, 1'b0, 1'b0, 7'h3F};
    vecs[19] = '{3'b010, 2'd0, 7'h3F, 1'b0, 1'b0, 7'h3F};
    vecs[20] = '{3'b000, 2'd0, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[21] = '{3'b000, 2'd0, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[22] = '{3'b000, 2'd0, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[23] = '{3'b100, 2'd1, 7'h00, 1'b1, 1'b0, 7'h01};
    vecs[24] = '{3'b100, 2'd1, 7'h00, 1'b0, 1'b0, 7'h01};
    vecs[25] = '{3'b100, 2'd1, 7'h01, 1'b0, 1'b0, 7'h01};
    vecs[26] = '{3'b111, 2'd1, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[27] = '{3'b111, 2'd1, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[28] = '{3'b111, 2'd1, 7'h00, 1'b0, 1'b0, 7'h00};
    vecs[29] = '{3'b111, 2'd1, 7'h00, 1'b0, 1'b1, 7'h00};
    vecs[30] = '{3'b111, 2'd1, 7'h00, 1'b0, 1'b1, 7'h00};
    vecs[31] = '{3'b010, 2'd1, 7'h00, 1'b0, 1'b1, 7'h03};
    vecs[32] = '{3'b010, 2'd1, 7'h00, 1'b0, 1'b1, 7'h03};
    vecs[33] = '{3'b010, 2'd1, 7'h03, 1'b0, 1'b1, 7'h03};
    vecs[34] = '{3'b001, 2'd1, 7'h00, 1'b0, 1'b1, 7'h07};
    vecs[35] = '{3'b100, 2'd2, 7'h00, 1'b1, 1'b0, 7'h07};
    vecs[36] = '{3'b100, 2'd2, 7'h00, 1'b0, 1'b0, 7'h07};
    vecs[37] = '{3'b100, 2'd2, 7'h07, 1'b0, 1'b0, 7'h07};

    // Bit i is whether frame i of the blink run is lit (last frame has blink disabled)
    litA = 7'b1011001;
    litB = 7'b1000111;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset rowA", rowA, 7'h00);
    checkOutput("reset rowB", rowB, 7'h00);
    checkOutput("reset frame_start", {6'b0, frameStartA}, 7'h00);
    checkOutput("reset col_fault", {6'b0, colFaultA}, 7'h00);
    reset = 1'b0;

    for (int i = 0; i < 38; i++) begin
      applyStimulus(vecs[i].col, vecs[i].sel, 1'b0);
      checkOutput($sformatf("vec%0d rowA", i), rowA, vecs[i].rowA);
      checkOutput($sformatf("vec%0d rowB", i), rowB, vecs[i].rowB);
      checkOutput($sformatf("vec%0d fsA", i), {6'b0, frameStartA}, {6'b0, vecs[i].fs});
      checkOutput($sformatf("vec%0d fsB", i), {6'b0, frameStartB}, {6'b0, vecs[i].fs});
      checkOutput($sformatf("vec%0d faultA", i), {6'b0, colFaultA}, {6'b0, vecs[i].fault});
      checkOutput($sformatf("vec%0d faultB", i), {6'b0, colFaultB}, {6'b0, vecs[i].fault});
    end

    // Blink run: six frames with blink enabled, then one with it disabled
    for (int f = 0; f < 7; f++) begin
      repeat (3) applyStimulus(3'b010, 2'd3, f < 6);
      repeat (3) applyStimulus(3'b001, 2'd3, f < 6);
      applyStimulus(3'b100, 2'd3, f < 6);
      checkOutput($sformatf("blink%0d fsA", f), {6'b0, frameStartA}, 7'h01);
      checkOutput($sformatf("blink%0d fsB", f), {6'b0, frameStartB}, 7'h01);
      repeat (2) applyStimulus(3'b100, 2'd3, f < 6);
      checkOutput($sformatf("blink%0d rowA", f), rowA, litA[f] ? 7'h1F : 7'h00);
      checkOutput($sformatf("blink%0d rowB", f), rowB, litB[f] ? 7'h1F : 7'h00);
    end

    // Reset in the middle of a blanking interval with pattern 3 latched
    applyStimulus(3'b010, 2'd3, 1'b0);
    checkOutput("preblank rowA", rowA, 7'h00);
    checkOutput("preblank rowB", rowB, 7'h3F);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset rowA", rowA, 7'h00);
    checkOutput("midreset rowB", rowB, 7'h00);
    checkOutput("midreset fsA", {6'b0, frameStartA}, 7'h00);
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(3'b010, 2'd0, 1'b0);
    checkOutput("postreset mid rowB", rowB, 7'h00);
    checkOutput("postreset mid rowA", rowA, 7'h00);
    applyStimulus(3'b001, 2'd0, 1'b0);
    checkOutput("postreset centre rowB", rowB, 7'h08);
    applyStimulus(3'b100, 2'd1, 1'b0);
    checkOutput("postreset fsA", {6'b0, frameStartA}, 7'h01);
    checkOutput("postreset fsB", {6'b0, frameStartB}, 7'h01);
    checkOutput("postreset outer rowB", rowB, 7'h01);
    repeat (2) applyStimulus(3'b100, 2'd1, 1'b0);
    checkOutput("postreset outer rowA", rowA, 7'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
